// File: rtl/rv_mul_res_pkg.sv
// Shared widths and operation encodings for the multiplier result stage.
package rv_mul_res_pkg;

  localparam int MUL_XLEN   = 64;
  localparam int MUL_TAG_W  = 5;
  localparam int MUL_TYPE_W = 3;

  // Same encoding the upstream multiplier array uses.
  localparam logic [MUL_TYPE_W-1:0] MUL_MUL_TYPE    = 3'd0;
  localparam logic [MUL_TYPE_W-1:0] MUL_MULH_TYPE   = 3'd1;
  localparam logic [MUL_TYPE_W-1:0] MUL_MULHSU_TYPE = 3'd2;
  localparam logic [MUL_TYPE_W-1:0] MUL_MULHU_TYPE  = 3'd3;
  localparam logic [MUL_TYPE_W-1:0] MUL_MULW_TYPE   = 3'd4;

endpackage

// File: rtl/rv_mul_res_sel.sv
// Combinational partial-product sum and RISC-V M-extension result select.
module rv_mul_res_sel
  import rv_mul_res_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic [MUL_TYPE_W-1:0] mul_type,
  input  logic [2*XLEN-1:0]     part0,
  input  logic [2*XLEN-1:0]     part1,
  output logic [XLEN-1:0]       res
);

  // MULW exists only on RV64; on RV32 it falls into the "unknown type" path.
  localparam bit HAS_W = (XLEN == 64);

  logic [2*XLEN-1:0] sum;
  logic [XLEN-1:0]   w_res;

  // Carry out of the top bit is intentionally dropped.
  assign sum = part0 + part1;

  assign w_res[31:0] = sum[31:0];

  // Sign-extension of the 32-bit word result; empty loop when XLEN is 32.
  for (genvar gi = 32; gi < XLEN; gi++) begin : g_wext
    assign w_res[gi] = sum[31];
  end

  // Pick the low or high half; signedness was already folded into the partials.
  always_comb begin
    res = '0;
    case (mul_type)
      MUL_MUL_TYPE:    res = sum[XLEN-1:0];
      MUL_MULH_TYPE,
      MUL_MULHSU_TYPE,
      MUL_MULHU_TYPE:  res = sum[2*XLEN-1:XLEN];
      MUL_MULW_TYPE:   res = HAS_W ? w_res : '0;
      default:         res = '0;
    endcase
  end

endmodule

// File: rtl/rv_mul_res.sv
// Two-stage multiplier result pipeline: capture partials, then sum/select into
// a held output register, with valid/ready on both sides and a flush kill.
module rv_mul_res
  import rv_mul_res_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_TYPE_W-1:0] mul_type,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [2*XLEN-1:0]     part_mul_res0,
  input  logic [2*XLEN-1:0]     part_mul_res1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  logic                  s1_valid;
  logic [2*XLEN-1:0]     s1_part0;
  logic [2*XLEN-1:0]     s1_part1;
  logic [MUL_TYPE_W-1:0] s1_type;
  logic [TAG_W-1:0]      s1_tag;
  logic                  s2_valid;
  logic [XLEN-1:0]       sel_res;
  logic                  s2_adv;
  logic                  accept;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~flush & (~s1_valid | s2_adv);
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  rv_mul_res_sel #(.XLEN(XLEN)) u_sel (
    .mul_type (s1_type),
    .part0    (s1_part0),
    .part1    (s1_part1),
    .res      (sel_res)
  );

  // S1 payload needs no reset: it is only observed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_part0 <= part_mul_res0;
      s1_part1 <= part_mul_res1;
      s1_type  <= mul_type;
      s1_tag   <= in_tag;
    end
  end

  // Valid bits and output register; output payload only changes on an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid <= 1'b1;
        out_data <= sel_res;
        out_tag  <= s1_tag;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_mul_res.sv
// Directed testbench for rv_mul_res with hand-computed expected results.
module tb_rv_mul_res;
  import rv_mul_res_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [MUL_TYPE_W-1:0] mul_type;
  logic [TAG_W-1:0]      in_tag;
  logic [2*XLEN-1:0]     part_mul_res0;
  logic [2*XLEN-1:0]     part_mul_res1;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic     mon_en = 1'b0;
  logic [TAG_W-1:0] mon_tags [$];
  int       mon_cycs [$];

  rv_mul_res #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mul_type      (mul_type),
    .in_tag        (in_tag),
    .part_mul_res0 (part_mul_res0),
    .part_mul_res1 (part_mul_res1),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each output handoff; sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      mon_tags.push_back(out_tag);
      mon_cycs.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [127:0] p0, input logic [127:0] p1,
                       input logic [4:0] tg);
    in_valid      = 1'b1;
    mul_type      = t;
    part_mul_res0 = p0;
    part_mul_res1 = p1;
    in_tag        = tg;
  endtask

  // Hold the op until in_ready is seen, bounded.
  task automatic push(input logic [2:0] t, input logic [127:0] p0, input logic [127:0] p1,
                      input logic [4:0] tg);
    int budget;
    budget = 20;
    drive(t, p0, p1, tg);
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check($sformatf("accept_timeout_t%0d", tg), 64'(in_ready), 64'd1);
    tick();
  endtask

  // Single op with no backpressure: checks latency, data, tag and valid drop.
  task automatic run_op(input string nm, input logic [2:0] t, input logic [127:0] p0,
                        input logic [127:0] p1, input logic [4:0] tg, input logic [63:0] exp);
    out_ready = 1'b1;
    drive(t, p0, p1, tg);
    #1;
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({nm, "_lat_s1"}, 64'(out_valid), 64'd0);
    tick();
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_data"}, out_data, exp);
    check({nm, "_tag"}, 64'(out_tag), 64'(tg));
    tick();
    check({nm, "_drop"}, 64'(out_valid), 64'd0);
    check({nm, "_hold"}, out_data, exp);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mul_type = '0; in_tag = '0; part_mul_res0 = '0; part_mul_res1 = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("mul", MUL_MUL_TYPE, 128'hF, 128'h0, 5'd3, 64'hF);
    run_op("mulhu_carry", MUL_MULHU_TYPE, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
           128'h1, 5'd4, 64'h1);
    run_op("mulw_sext", MUL_MULW_TYPE, 128'h0000_0000_8000_0000, 128'h0, 5'd5,
           64'hFFFF_FFFF_8000_0000);
    run_op("mulw_pos", MUL_MULW_TYPE, 128'h1234_0000_7FFF_FFFE, 128'h1, 5'd6,
           64'h0000_0000_7FFF_FFFF);
    run_op("mulh", MUL_MULH_TYPE, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 128'h0,
           5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulhsu", MUL_MULHSU_TYPE, 128'h0000_0000_0000_1234_0000_0000_0000_0000,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 5'd8, 64'h1235);
    run_op("mul_lo", MUL_MUL_TYPE, 128'h5_0000_0000_0000_0003, 128'h2_0000_0000_0000_0004,
           5'd9, 64'h7);
    run_op("mul_wrap", MUL_MUL_TYPE, {128{1'b1}}, 128'h2, 5'd10, 64'h1);
    run_op("bad_type", 3'b111, 128'hDEAD_BEEF, 128'h1, 5'd11, 64'h0);

    // Backpressure: S2 holds op 1, S1 fills with op 2, then in_ready drops.
    out_ready = 1'b0;
    mon_tags.delete();
    mon_cycs.delete();
    mon_en = 1'b1;
    push(MUL_MUL_TYPE, 128'd1, 128'd0, 5'd1);
    push(MUL_MUL_TYPE, 128'd2, 128'd0, 5'd2);
    drive(MUL_MUL_TYPE, 128'd3, 128'd0, 5'd3);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_hold_data_%0d", i), out_data, 64'd1);
      check($sformatf("bp_hold_tag_%0d", i), 64'(out_tag), 64'd1);
      check($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    push(MUL_MUL_TYPE, 128'd3, 128'd0, 5'd3);
    push(MUL_MUL_TYPE, 128'd4, 128'd0, 5'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && mon_tags.size() < 4; i++) tick();
    tick();
    mon_en = 1'b0;
    check("bp_count", 64'(mon_tags.size()), 64'd4);
    for (int i = 0; i < 4 && i < mon_tags.size(); i++) begin
      check($sformatf("bp_order_%0d", i), 64'(mon_tags[i]), 64'(i + 1));
      if (i > 0) check($sformatf("bp_gap_%0d", i), 64'(mon_cycs[i] - mon_cycs[i-1]), 64'd1);
    end
    check("bp_drained", 64'(busy), 64'd0);

    // Flush with two ops in flight and a third presented during the flush.
    out_ready = 1'b0;
    push(MUL_MUL_TYPE, 128'd5, 128'd0, 5'd5);
    push(MUL_MUL_TYPE, 128'd6, 128'd0, 5'd6);
    in_valid = 1'b0;
    check("fl_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    drive(MUL_MUL_TYPE, 128'd7, 128'd0, 5'd7);
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    check("fl_out_valid_during", 64'(out_valid), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    tick();
    check("fl_no_ghost", 64'(busy), 64'd0);
    run_op("post_flush", MUL_MUL_TYPE, 128'h8, 128'h0, 5'd8, 64'h8);

    // Reset with two ops in flight discards them.
    out_ready = 1'b0;
    push(MUL_MULHU_TYPE, 128'hAA_0000_0000_0000_0000, 128'd0, 5'd12);
    push(MUL_MUL_TYPE, 128'd13, 128'd0, 5'd13);
    in_valid = 1'b0;
    check("rs_out_data_pre", out_data, 64'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_out_data", out_data, 64'd0);
    check("rs_out_tag", 64'(out_tag), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_busy", 64'(busy), 64'd0);
    tick();
    check("rs_still_idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
